execute_bru_issue_ctrl: RTL and testbench

In-order branch issue controller in front of the BRU condition evaluator. Buffers up to DEPTH branch micro-ops from dispatch and captures missing operands from writeback broadcasts. Issues the oldest entry once both operands are present, evaluates taken/not-taken, and presents a registered resolution (taken, mispredict, ROB id) to commit with a valid/ready handshake.

---
 rtl/execute_bru_issue_ctrl_pkg.sv | 63 ++++++
 rtl/execute_bru_issue_ctrl_cond.sv | 31 +++
 rtl/execute_bru_issue_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_execute_bru_issue_ctrl.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_bru_issue_ctrl_pkg.sv
// Shared definitions for the BRU issue controller: command bit positions,
// queue entry layout and the writeback snoop helper.
package execute_bru_issue_ctrl_pkg;

  localparam int BRU_CMD_W   = 7;
  localparam int BRU_CMD_JMP = 6;
  localparam int BRU_CMD_GTZ = 4;
  localparam int BRU_CMD_EZ  = 3;
  localparam int BRU_CMD_LTZ = 2;
  localparam int BRU_CMD_EQ  = 1;
  localparam int BRU_CMD_NE  = 0;

  localparam int BRU_TAG_W = 6;
  localparam int BRU_ROB_W = 5;

  typedef struct packed {
    logic                 valid;
    logic [BRU_CMD_W-1:0] cmd;
    logic                 src0_rdy;
    logic [BRU_TAG_W-1:0] src0_tag;
    logic [31:0]          src0_value;
    logic                 src1_rdy;
    logic [BRU_TAG_W-1:0] src1_tag;
    logic [31:0]          src1_value;
    logic                 pred;
    logic [BRU_ROB_W-1:0] rob;
  } bru_entry_t;

  typedef struct packed {
    logic        rdy;
    logic [31:0] value;
  } bru_opnd_t;

  localparam bru_entry_t BRU_ENTRY_NULL = '0;

  // A ready operand is never overwritten; wb0 takes priority over wb1.
  function automatic bru_opnd_t bru_snoop(
    input logic                 rdy,
    input logic [BRU_TAG_W-1:0] tag,
    input logic [31:0]          value,
    input logic                 wb0_valid,
    input logic [BRU_TAG_W-1:0] wb0_tag,
    input logic [31:0]          wb0_value,
    input logic                 wb1_valid,
    input logic [BRU_TAG_W-1:0] wb1_tag,
    input logic [31:0]          wb1_value
  );
    bru_opnd_t r;
    r.rdy   = rdy;
    r.value = value;
    if (!rdy && wb0_valid && (wb0_tag == tag)) begin
      r.rdy   = 1'b1;
      r.value = wb0_value;
    end else if (!rdy && wb1_valid && (wb1_tag == tag)) begin
      r.rdy   = 1'b1;
      r.value = wb1_value;
    end else begin
      r.rdy   = rdy;
    end
    return r;
  endfunction

endpackage

// File: rtl/execute_bru_issue_ctrl_cond.sv
// Combinational BRU condition evaluator: decides taken/not-taken from the
// command bitmask and the two 32-bit operands.
module execute_bru_impl_cond
  import execute_bru_issue_ctrl_pkg::*;
(
  input  logic [BRU_CMD_W-1:0] i_cmd,
  input  logic [31:0]          i_src0,
  input  logic [31:0]          i_src1,
  output logic                 o_taken
);

  logic w_ez;
  logic w_ltz;
  logic w_gtz;
  logic w_eq;
  logic w_unused_cmd5;

  assign w_ez          = (i_src0 == 32'd0);
  assign w_ltz         = i_src0[31];
  assign w_gtz         = !w_ltz && !w_ez;
  assign w_eq          = (i_src0 == i_src1);
  assign w_unused_cmd5 = i_cmd[5];

  assign o_taken = i_cmd[BRU_CMD_JMP]
                 | (i_cmd[BRU_CMD_GTZ] & w_gtz)
                 | (i_cmd[BRU_CMD_EZ]  & w_ez)
                 | (i_cmd[BRU_CMD_LTZ] & w_ltz)
                 | (i_cmd[BRU_CMD_EQ]  & w_eq)
                 | (i_cmd[BRU_CMD_NE]  & !w_eq);

endmodule

// File: rtl/execute_bru_issue_ctrl.sv
// In-order branch issue queue with operand wakeup and a registered resolution
// port. Define BRU_ISSUE_BYPASS_EN to let ready ops skip an empty queue.
module execute_bru_issue_ctrl
  import execute_bru_issue_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = BRU_TAG_W,
  parameter int ROB_W = BRU_ROB_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_enq_valid,
  output logic             o_enq_ready,
  input  logic [6:0]       i_enq_cmd,
  input  logic             i_enq_src0_rdy,
  input  logic             i_enq_src1_rdy,
  input  logic [TAG_W-1:0] i_enq_src0_tag,
  input  logic [TAG_W-1:0] i_enq_src1_tag,
  input  logic [31:0]      i_enq_src0_value,
  input  logic [31:0]      i_enq_src1_value,
  input  logic             i_enq_pred_taken,
  input  logic [ROB_W-1:0] i_enq_rob,
  input  logic             i_wb0_valid,
  input  logic [TAG_W-1:0] i_wb0_tag,
  input  logic [31:0]      i_wb0_value,
  input  logic             i_wb1_valid,
  input  logic [TAG_W-1:0] i_wb1_tag,
  input  logic [31:0]      i_wb1_value,
  input  logic             i_flush,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic             o_res_taken,
  output logic             o_res_mispred,
  output logic [ROB_W-1:0] o_res_rob,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  bru_entry_t       r_ent     [DEPTH];
  bru_entry_t       w_ent_nxt [DEPTH];
  bru_opnd_t        w_wk0     [DEPTH];
  bru_opnd_t        w_wk1     [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_res_valid;
  logic             r_res_taken;
  logic             r_res_mispred;
  logic [ROB_W-1:0] r_res_rob;

  bru_opnd_t        w_enq_op0;
  bru_opnd_t        w_enq_op1;
  bru_entry_t       w_new;
  logic             w_enq;
  logic             w_store;
  logic             w_out_free;
  logic             w_issue;
  logic             w_bypass;
  logic             w_taken;
  logic [6:0]       w_ev_cmd;
  logic [31:0]      w_ev_src0;
  logic [31:0]      w_ev_src1;
  logic             w_ev_pred;
  logic [ROB_W-1:0] w_ev_rob;

  assign o_enq_ready   = (r_count < CNT_W'(DEPTH));
  assign o_empty       = (r_count == {CNT_W{1'b0}});
  assign o_res_valid   = r_res_valid;
  assign o_res_taken   = r_res_taken;
  assign o_res_mispred = r_res_mispred;
  assign o_res_rob     = r_res_rob;

  assign w_enq      = i_enq_valid & o_enq_ready;
  assign w_out_free = !r_res_valid | i_res_ready;
  assign w_issue    = r_ent[r_head].valid & r_ent[r_head].src0_rdy
                    & r_ent[r_head].src1_rdy & w_out_free;

  assign w_enq_op0 = bru_snoop(i_enq_src0_rdy, i_enq_src0_tag, i_enq_src0_value,
                               i_wb0_valid, i_wb0_tag, i_wb0_value,
                               i_wb1_valid, i_wb1_tag, i_wb1_value);
  assign w_enq_op1 = bru_snoop(i_enq_src1_rdy, i_enq_src1_tag, i_enq_src1_value,
                               i_wb0_valid, i_wb0_tag, i_wb0_value,
                               i_wb1_valid, i_wb1_tag, i_wb1_value);

`ifdef BRU_ISSUE_BYPASS_EN
  assign w_bypass = w_enq & (r_count == {CNT_W{1'b0}}) & w_enq_op0.rdy
                  & w_enq_op1.rdy & w_out_free;
`else
  assign w_bypass = 1'b0;
`endif
  assign w_store = w_enq & !w_bypass;

  // A bypass only happens with an empty queue, so the evaluator is free then.
  assign w_ev_cmd  = w_bypass ? i_enq_cmd       : r_ent[r_head].cmd;
  assign w_ev_src0 = w_bypass ? w_enq_op0.value : r_ent[r_head].src0_value;
  assign w_ev_src1 = w_bypass ? w_enq_op1.value : r_ent[r_head].src1_value;
  assign w_ev_pred = w_bypass ? i_enq_pred_taken : r_ent[r_head].pred;
  assign w_ev_rob  = w_bypass ? i_enq_rob       : r_ent[r_head].rob;

  execute_bru_impl_cond u_cond (
    .i_cmd   (w_ev_cmd),
    .i_src0  (w_ev_src0),
    .i_src1  (w_ev_src1),
    .o_taken (w_taken)
  );

  for (genvar g = 0; g < DEPTH; g++) begin : g_wake
    assign w_wk0[g] = bru_snoop(r_ent[g].src0_rdy, r_ent[g].src0_tag, r_ent[g].src0_value,
                                i_wb0_valid, i_wb0_tag, i_wb0_value,
                                i_wb1_valid, i_wb1_tag, i_wb1_value);
    assign w_wk1[g] = bru_snoop(r_ent[g].src1_rdy, r_ent[g].src1_tag, r_ent[g].src1_value,
                                i_wb0_valid, i_wb0_tag, i_wb0_value,
                                i_wb1_valid, i_wb1_tag, i_wb1_value);
  end

  // Build the entry written at the tail on enqueue
  always_comb begin
    w_new            = BRU_ENTRY_NULL;
    w_new.valid      = 1'b1;
    w_new.cmd        = i_enq_cmd;
    w_new.src0_rdy   = w_enq_op0.rdy;
    w_new.src0_tag   = i_enq_src0_tag;
    w_new.src0_value = w_enq_op0.value;
    w_new.src1_rdy   = w_enq_op1.rdy;
    w_new.src1_tag   = i_enq_src1_tag;
    w_new.src1_value = w_enq_op1.value;
    w_new.pred       = i_enq_pred_taken;
    w_new.rob        = i_enq_rob;
  end

  // Next entry state: wakeup everywhere, then pop at head or write at tail
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_ent_nxt[i]            = r_ent[i];
      w_ent_nxt[i].src0_rdy   = w_wk0[i].rdy;
      w_ent_nxt[i].src0_value = w_wk0[i].value;
      w_ent_nxt[i].src1_rdy   = w_wk1[i].rdy;
      w_ent_nxt[i].src1_value = w_wk1[i].value;
      if (w_store && (r_tail == PTR_W'(i))) begin
        w_ent_nxt[i] = w_new;
      end else if (w_issue && (r_head == PTR_W'(i))) begin
        w_ent_nxt[i].valid = 1'b0;
      end else begin
        w_ent_nxt[i].valid = r_ent[i].valid;
      end
    end
  end

  // Queue storage, pointers and occupancy
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= BRU_ENTRY_NULL;
      r_head  <= {PTR_W{1'b0}};
      r_tail  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= BRU_ENTRY_NULL;
      r_head  <= {PTR_W{1'b0}};
      r_tail  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= w_ent_nxt[i];
      if (w_issue) r_head <= r_head + PTR_W'(1);
      if (w_store) r_tail <= r_tail + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_store) - CNT_W'(w_issue);
    end
  end

  // Resolution register toward commit
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_res_valid   <= 1'b0;
      r_res_taken   <= 1'b0;
      r_res_mispred <= 1'b0;
      r_res_rob     <= {ROB_W{1'b0}};
    end else if (i_flush) begin
      r_res_valid   <= 1'b0;
      r_res_taken   <= 1'b0;
      r_res_mispred <= 1'b0;
      r_res_rob     <= {ROB_W{1'b0}};
    end else if (w_issue || w_bypass) begin
      r_res_valid   <= 1'b1;
      r_res_taken   <= w_taken;
      r_res_mispred <= w_taken ^ w_ev_pred;
      r_res_rob     <= w_ev_rob;
    end else if (i_res_ready) begin
      r_res_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute_bru_issue_ctrl.sv
// Self-checking bench for execute_bru_issue_ctrl: condition table, directed
// multi-cycle sequences and random traffic against a queue-based model.
`timescale 1ns/1ps
module tb_execute_bru_issue_ctrl;
  import execute_bru_issue_ctrl_pkg::*;

  localparam int DEPTH = 4;
`ifdef BRU_ISSUE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk;
  logic        resetn;
  logic        i_enq_valid;
  logic        o_enq_ready;
  logic [6:0]  i_enq_cmd;
  logic        i_enq_src0_rdy, i_enq_src1_rdy;
  logic [5:0]  i_enq_src0_tag, i_enq_src1_tag;
  logic [31:0] i_enq_src0_value, i_enq_src1_value;
  logic        i_enq_pred_taken;
  logic [4:0]  i_enq_rob;
  logic        i_wb0_valid, i_wb1_valid;
  logic [5:0]  i_wb0_tag, i_wb1_tag;
  logic [31:0] i_wb0_value, i_wb1_value;
  logic        i_flush;
  logic        o_res_valid;
  logic        i_res_ready;
  logic        o_res_taken;
  logic        o_res_mispred;
  logic [4:0]  o_res_rob;
  logic        o_empty;

  execute_bru_issue_ctrl #(.DEPTH(DEPTH), .TAG_W(6), .ROB_W(5)) dut (
    .clk(clk), .resetn(resetn),
    .i_enq_valid(i_enq_valid), .o_enq_ready(o_enq_ready), .i_enq_cmd(i_enq_cmd),
    .i_enq_src0_rdy(i_enq_src0_rdy), .i_enq_src1_rdy(i_enq_src1_rdy),
    .i_enq_src0_tag(i_enq_src0_tag), .i_enq_src1_tag(i_enq_src1_tag),
    .i_enq_src0_value(i_enq_src0_value), .i_enq_src1_value(i_enq_src1_value),
    .i_enq_pred_taken(i_enq_pred_taken), .i_enq_rob(i_enq_rob),
    .i_wb0_valid(i_wb0_valid), .i_wb0_tag(i_wb0_tag), .i_wb0_value(i_wb0_value),
    .i_wb1_valid(i_wb1_valid), .i_wb1_tag(i_wb1_tag), .i_wb1_value(i_wb1_value),
    .i_flush(i_flush), .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
    .o_res_taken(o_res_taken), .o_res_mispred(o_res_mispred), .o_res_rob(o_res_rob),
    .o_empty(o_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of waiting branches plus one output slot.
  typedef struct packed {
    logic [6:0]  cmd;
    logic        r0, r1;
    logic [5:0]  t0, t1;
    logic [31:0] v0, v1;
    logic        pred;
    logic [4:0]  rob;
  } mop_t;

  mop_t       mq[$];
  logic       m_valid, m_taken, m_mis;
  logic [4:0] m_rob;

  function automatic logic ref_taken(input logic [6:0] cmd, input logic [31:0] a, input logic [31:0] b);
    logic t;
    t = 1'b0;
    if (cmd[6]) t = 1'b1;
    if (cmd[4] && ($signed(a) > 32'sd0)) t = 1'b1;
    if (cmd[3] && (a == 32'd0)) t = 1'b1;
    if (cmd[2] && ($signed(a) < 32'sd0)) t = 1'b1;
    if (cmd[1] && (a == b)) t = 1'b1;
    if (cmd[0] && (a != b)) t = 1'b1;
    return t;
  endfunction

  function automatic mop_t wake(input mop_t m);
    mop_t r;
    r = m;
    if (!r.r0 && i_wb0_valid && i_wb0_tag == r.t0) begin r.r0 = 1'b1; r.v0 = i_wb0_value; end
    else if (!r.r0 && i_wb1_valid && i_wb1_tag == r.t0) begin r.r0 = 1'b1; r.v0 = i_wb1_value; end
    if (!r.r1 && i_wb0_valid && i_wb0_tag == r.t1) begin r.r1 = 1'b1; r.v1 = i_wb0_value; end
    else if (!r.r1 && i_wb1_valid && i_wb1_tag == r.t1) begin r.r1 = 1'b1; r.v1 = i_wb1_value; end
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_valid = 1'b0; m_taken = 1'b0; m_mis = 1'b0; m_rob = 5'd0;
  endtask

  task automatic resolve(input mop_t m);
    m_valid = 1'b1;
    m_taken = ref_taken(m.cmd, m.v0, m.v1);
    m_mis   = m_taken ^ m.pred;
    m_rob   = m.rob;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    mop_t nw, head;
    bit   enq_ok, free_out, iss, byp;
    if (i_flush) begin
      mq.delete();
      m_valid = 1'b0;
      return;
    end
    nw = wake('{i_enq_cmd, i_enq_src0_rdy, i_enq_src1_rdy, i_enq_src0_tag, i_enq_src1_tag,
                i_enq_src0_value, i_enq_src1_value, i_enq_pred_taken, i_enq_rob});
    enq_ok   = i_enq_valid && (mq.size() < DEPTH);
    free_out = !m_valid || i_res_ready;
    iss      = (mq.size() > 0) && mq[0].r0 && mq[0].r1 && free_out;
    byp      = 1'b0;
`ifdef BRU_ISSUE_BYPASS_EN
    byp      = enq_ok && (mq.size() == 0) && nw.r0 && nw.r1 && free_out;
`endif
    if (iss) begin
      head = mq.pop_front();
      resolve(head);
    end else if (byp) begin
      resolve(nw);
    end else if (i_res_ready) begin
      m_valid = 1'b0;
    end
    foreach (mq[i]) mq[i] = wake(mq[i]);
    if (enq_ok && !byp) mq.push_back(nw);
  endtask

  task automatic compare_model();
    check("m_res_valid", o_res_valid, m_valid);
    check("m_enq_ready", o_enq_ready, mq.size() < DEPTH);
    check("m_empty", o_empty, mq.size() == 0);
    if (m_valid) begin
      check("m_taken", o_res_taken, m_taken);
      check("m_mispred", o_res_mispred, m_mis);
      check("m_rob", o_res_rob, m_rob);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  task automatic idle();
    i_enq_valid = 1'b0; i_enq_cmd = 7'd0;
    i_enq_src0_rdy = 1'b0; i_enq_src1_rdy = 1'b0;
    i_enq_src0_tag = 6'd0; i_enq_src1_tag = 6'd0;
    i_enq_src0_value = 32'd0; i_enq_src1_value = 32'd0;
    i_enq_pred_taken = 1'b0; i_enq_rob = 5'd0;
    i_wb0_valid = 1'b0; i_wb0_tag = 6'd0; i_wb0_value = 32'd0;
    i_wb1_valid = 1'b0; i_wb1_tag = 6'd0; i_wb1_value = 32'd0;
    i_flush = 1'b0;
  endtask

  task automatic set_enq(input logic [6:0] cmd, input logic r0, input logic [5:0] t0, input logic [31:0] v0,
                         input logic r1, input logic [5:0] t1, input logic [31:0] v1,
                         input logic pred, input logic [4:0] rob);
    i_enq_valid = 1'b1; i_enq_cmd = cmd;
    i_enq_src0_rdy = r0; i_enq_src0_tag = t0; i_enq_src0_value = v0;
    i_enq_src1_rdy = r1; i_enq_src1_tag = t1; i_enq_src1_value = v1;
    i_enq_pred_taken = pred; i_enq_rob = rob;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, o_res_valid, 1'b0);
    check({tag, "_taken"}, o_res_taken, 1'b0);
    check({tag, "_mispred"}, o_res_mispred, 1'b0);
    check({tag, "_rob"}, o_res_rob, 5'd0);
    check({tag, "_enq_ready"}, o_enq_ready, 1'b1);
    check({tag, "_empty"}, o_empty, 1'b1);
  endtask

  function automatic logic [31:0] rval();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  typedef struct packed {
    logic [6:0]  cmd;
    logic [31:0] s0, s1;
    logic        pred;
    logic        exp_taken;
    logic        exp_mis;
  } vec_t;

  vec_t vecs [14];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{7'h02, 32'h5, 32'h5, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{7'h01, 32'h5, 32'h6, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{7'h01, 32'h5, 32'h5, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{7'h10, 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{7'h10, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{7'h10, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{7'h08, 32'h0, 32'h9, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{7'h08, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{7'h04, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{7'h04, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{7'h40, 32'h3, 32'h4, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{7'h00, 32'h5, 32'h5, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{7'h18, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{7'h03, 32'h3, 32'h4, 1'b1, 1'b1, 1'b0};

    idle();
    i_res_ready = 1'b1;
    resetn = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_state("reset");
    resetn = 1'b1;
    cycle();

    // Condition table, one branch at a time with ready operands.
    for (int i = 0; i < 14; i++) begin
      set_enq(vecs[i].cmd, 1'b1, 6'd0, vecs[i].s0, 1'b1, 6'd0, vecs[i].s1, vecs[i].pred, 5'(i));
      cycle();
      idle();
      check("vec_first_cycle_valid", o_res_valid, (LAT == 1));
      for (int k = 1; k < LAT; k++) cycle();
      check("vec_valid", o_res_valid, 1'b1);
      check("vec_taken", o_res_taken, vecs[i].exp_taken);
      check("vec_mispred", o_res_mispred, vecs[i].exp_mis);
      check("vec_rob", o_res_rob, 5'(i));
      cycle();
    end

    // LTZ with a late operand from wb1.
    set_enq(7'h04, 1'b0, 6'd7, 32'd0, 1'b1, 6'd0, 32'd0, 1'b0, 5'd20);
    cycle(); idle();
    cycle();
    i_wb1_valid = 1'b1; i_wb1_tag = 6'd7; i_wb1_value = 32'h8000_0000;
    cycle(); idle();
    check("ltz_not_yet", o_res_valid, 1'b0);
    cycle();
    check("ltz_valid", o_res_valid, 1'b1);
    check("ltz_taken", o_res_taken, 1'b1);
    check("ltz_rob", o_res_rob, 5'd20);
    cycle();

    // wb0 beats wb1 on the same tag.
    set_enq(7'h10, 1'b0, 6'd9, 32'd0, 1'b1, 6'd0, 32'd0, 1'b0, 5'd3);
    cycle(); idle();
    i_wb0_valid = 1'b1; i_wb0_tag = 6'd9; i_wb0_value = 32'd1;
    i_wb1_valid = 1'b1; i_wb1_tag = 6'd9; i_wb1_value = 32'd2;
    cycle(); idle();
    cycle();
    check("prio_gtz_taken", o_res_taken, 1'b1);
    cycle();
    set_enq(7'h02, 1'b0, 6'd9, 32'd0, 1'b1, 6'd0, 32'd1, 1'b0, 5'd4);
    cycle(); idle();
    i_wb0_valid = 1'b1; i_wb0_tag = 6'd9; i_wb0_value = 32'd1;
    i_wb1_valid = 1'b1; i_wb1_tag = 6'd9; i_wb1_value = 32'd2;
    cycle(); idle();
    cycle();
    check("prio_eq_valid", o_res_valid, 1'b1);
    check("prio_eq_taken", o_res_taken, 1'b1);
    cycle();

    // Both operands arrive by broadcast in the enqueue cycle.
    set_enq(7'h02, 1'b0, 6'd12, 32'd0, 1'b0, 6'd13, 32'd0, 1'b1, 5'd6);
    i_wb0_valid = 1'b1; i_wb0_tag = 6'd12; i_wb0_value = 32'd4;
    i_wb1_valid = 1'b1; i_wb1_tag = 6'd13; i_wb1_value = 32'd4;
    cycle(); idle();
    for (int k = 1; k < LAT; k++) cycle();
    check("snoop_valid", o_res_valid, 1'b1);
    check("snoop_taken", o_res_taken, 1'b1);
    check("snoop_mispred", o_res_mispred, 1'b0);
    cycle();

    // Fill the queue while commit stalls, then drain in order.
    i_res_ready = 1'b0;
    set_enq(7'h01, 1'b0, 6'd30, 32'd0, 1'b1, 6'd0, 32'd5, 1'b0, 5'd1); cycle();
    set_enq(7'h40, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0, 1'b1, 5'd2); cycle();
    set_enq(7'h40, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0, 1'b1, 5'd3); cycle();
    set_enq(7'h40, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0, 1'b1, 5'd4); cycle();
    check("full_enq_ready", o_enq_ready, 1'b0);
    check("full_empty", o_empty, 1'b0);
    set_enq(7'h40, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0, 1'b1, 5'd5); cycle();
    idle();
    i_wb0_valid = 1'b1; i_wb0_tag = 6'd30; i_wb0_value = 32'd7;
    cycle(); idle();
    check("full_still_ready0", o_enq_ready, 1'b0);
    cycle();
    check("full_issue_valid", o_res_valid, 1'b1);
    check("full_issue_rob", o_res_rob, 5'd1);
    check("full_issue_taken", o_res_taken, 1'b1);
    check("full_after_issue_ready", o_enq_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("hold_valid", o_res_valid, 1'b1);
      check("hold_rob", o_res_rob, 5'd1);
      check("hold_mispred", o_res_mispred, 1'b1);
    end
    i_res_ready = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      cycle();
      check("drain_rob", o_res_rob, 5'(k));
      check("drain_valid", o_res_valid, 1'b1);
    end
    cycle();
    check("drain_done", o_res_valid, 1'b0);
    check("drain_empty", o_empty, 1'b1);

    // Flush with buffered entries, a pending result and a same-cycle enqueue.
    i_res_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_enq(7'h40, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0, 1'b0, 5'(10 + k));
      cycle();
    end
    idle();
    check("preflush_valid", o_res_valid, 1'b1);
    check("preflush_empty", o_empty, 1'b0);
    set_enq(7'h40, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0, 1'b0, 5'd14);
    i_flush = 1'b1;
    cycle(); idle();
    check("flush_empty", o_empty, 1'b1);
    check("flush_valid", o_res_valid, 1'b0);
    check("flush_enq_ready", o_enq_ready, 1'b1);
    cycle();
    check("flush_drop_empty", o_empty, 1'b1);
    check("flush_drop_valid", o_res_valid, 1'b0);
    i_res_ready = 1'b1;

    // Unconditional jump into an empty queue.
    set_enq(7'h40, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0, 1'b1, 5'd9);
    cycle(); idle();
    check("jmp_n1_valid", o_res_valid, (LAT == 1));
    check("jmp_n1_empty", o_empty, (LAT == 1));
    cycle();
    check("jmp_n2_valid", o_res_valid, (LAT == 2));

    // Asynchronous reset in the middle of traffic.
    i_res_ready = 1'b0;
    set_enq(7'h40, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0, 1'b0, 5'd17); cycle();
    set_enq(7'h02, 1'b0, 6'd5, 32'd0, 1'b1, 6'd0, 32'd0, 1'b0, 5'd18); cycle();
    idle();
    #2 resetn = 1'b0;
    #1 check_reset_state("midreset");
    model_reset();
    @(negedge clk);
    check_reset_state("inreset");
    resetn = 1'b1;
    i_res_ready = 1'b1;
    cycle();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      idle();
      i_res_ready = ($urandom_range(0, 9) < 7);
      i_flush     = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 1) == 1) begin
        set_enq(($urandom_range(0, 3) == 0) ? 7'($urandom()) : 7'(7'd1 << $urandom_range(0, 6)),
                1'($urandom()), 6'($urandom_range(0, 7)), rval(),
                1'($urandom()), 6'($urandom_range(0, 7)), rval(),
                1'($urandom()), 5'($urandom()));
      end
      if ($urandom_range(0, 1) == 1) begin
        i_wb0_valid = 1'b1; i_wb0_tag = 6'($urandom_range(0, 7)); i_wb0_value = rval();
      end
      if ($urandom_range(0, 2) == 0) begin
        i_wb1_valid = 1'b1; i_wb1_tag = 6'($urandom_range(0, 7)); i_wb1_value = rval();
      end
      cycle();
    end

    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
